reg_writeback: RTL and testbench

- Write-side companion to the processor register file: it produces the `wb`/`dst`/`reg_write` write port the file consumes.
- Merges single-cycle ALU results with variable-latency load results returned by the memory interface.
- Buffers load results in a small FIFO and drives at most one register write per cycle.
- Keeps a per-register pending scoreboard so decode can stall on reads of registers with loads outstanding.

---
 rtl/reg_writeback.sv | 89 ++++++++
 tb/tb_reg_writeback.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU and load results into one register-file write port, with a pending-load scoreboard.
// Optional WB_FORWARD_EN adds fwd_a_hit/fwd_b_hit/fwd_data and clears pending one cycle earlier.
module reg_writeback #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             alu_valid,
    input  logic [4:0]       alu_dst,
    input  logic [31:0]      alu_data,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [4:0]       mem_dst,
    input  logic [31:0]      mem_data,
    input  logic             load_issue,
    input  logic [4:0]       load_dst,
    input  logic [4:0]       addr_a,
    input  logic [4:0]       addr_b,
    output logic             stall,
    output logic [31:0]      wb,
    output logic [4:0]       dst,
    output logic             reg_write,
`ifdef WB_FORWARD_EN
    output logic             fwd_a_hit,
    output logic             fwd_b_hit,
    output logic [31:0]      fwd_data,
`endif
    output logic [CNT_W-1:0] fifo_count
);
    localparam int PW = $clog2(DEPTH);
    logic [4:0]       q_dst  [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      pending, set_mask, clr_mask, sel_data;
    logic [4:0]       sel_dst;
    logic             empty, push, pop, sel_valid;
    assign empty      = count == '0;
    assign mem_ready  = count != CNT_W'(DEPTH);
    assign push       = mem_valid & mem_ready;
    assign pop        = !alu_valid & !empty;
    assign sel_valid  = alu_valid | !empty;
    assign sel_dst    = alu_valid ? alu_dst : q_dst[rd_ptr];
    assign sel_data   = alu_valid ? alu_data : q_data[rd_ptr];
    assign fifo_count = count;
    assign stall      = pending[addr_a] | pending[addr_b];
`ifdef WB_FORWARD_EN
    assign fwd_a_hit = reg_write & (dst == addr_a) & (dst != 5'd0);
    assign fwd_b_hit = reg_write & (dst == addr_b) & (dst != 5'd0);
    assign fwd_data  = wb;
`endif
    always_comb begin
        set_mask = (load_issue && load_dst != 5'd0) ? 32'd1 << load_dst : 32'd0;
`ifdef WB_FORWARD_EN
        // Clear as the write is selected so stall drops while it is presented.
        clr_mask = (sel_valid && sel_dst != 5'd0) ? 32'd1 << sel_dst : 32'd0;
`else
        clr_mask = reg_write ? 32'd1 << dst : 32'd0;
`endif
    end
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            q_dst[wr_ptr]  <= mem_dst;
            q_data[wr_ptr] <= mem_data;
        end
    end
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pending   <= '0;
            wb        <= '0;
            dst       <= '0;
            reg_write <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count     <= count + CNT_W'(push) - CNT_W'(pop);
            pending   <= (pending & ~clr_mask) | set_mask;
            reg_write <= sel_valid && sel_dst != 5'd0;
            if (sel_valid) begin
                wb  <= sel_data;
                dst <= sel_dst;
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed checks of reg_writeback write selection, FIFO, scoreboard and reset.
module tb_reg_writeback;
    logic        CLOCK_50 = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, load_issue = 1'b0;
    logic [4:0]  alu_dst = '0, mem_dst = '0, load_dst = '0, addr_a = '0, addr_b = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        mem_ready, stall, reg_write;
    logic [31:0] wb;
    logic [4:0]  dst;
    logic [2:0]  fifo_count;
`ifdef WB_FORWARD_EN
    logic        fwd_a_hit, fwd_b_hit;
    logic [31:0] fwd_data;
`endif
    int n_cmp = 0, n_bad = 0;

    reg_writeback dut (
        .CLOCK_50(CLOCK_50), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst(mem_dst), .mem_data(mem_data),
        .load_issue(load_issue), .load_dst(load_dst), .addr_a(addr_a), .addr_b(addr_b),
        .stall(stall), .wb(wb), .dst(dst), .reg_write(reg_write),
`ifdef WB_FORWARD_EN
        .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit), .fwd_data(fwd_data),
`endif
        .fifo_count(fifo_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        // reset held with ALU traffic present
        alu_valid = 1; alu_dst = 3; alu_data = 32'h1;
        tick(); tick();
        #1;
        chk("rst_rw", reg_write, 0);
        chk("rst_ready", mem_ready, 1);
        chk("rst_cnt", fifo_count, 0);
        chk("rst_stall", stall, 0);
        chk("rst_dst", dst, 0);
        chk("rst_wb", wb, 0);
        rst_n = 1;
        tick();
        chk("rel_rw", reg_write, 1);
        chk("rel_dst", dst, 3);
        chk("rel_wb", wb, 1);
        alu_valid = 0;
        tick();
        chk("rel_rw_off", reg_write, 0);

        // single ALU write
        alu_valid = 1; alu_dst = 5; alu_data = 32'hFF;
        tick();
        alu_valid = 0;
        chk("alu_rw", reg_write, 1);
        chk("alu_dst", dst, 5);
        chk("alu_wb", wb, 32'hFF);
        tick();
        chk("alu_rw_off", reg_write, 0);
        chk("alu_dst_hold", dst, 5);
        chk("alu_wb_hold", wb, 32'hFF);

        // load scoreboard: issue in cycle 0, data in cycle 3
        load_issue = 1; load_dst = 7; addr_a = 7;
        #1 chk("sb_c0_stall", stall, 0);
        tick();
        load_issue = 0;
        #1 chk("sb_c1_stall", stall, 1);
        tick(); tick();
        mem_valid = 1; mem_dst = 7; mem_data = 32'hDEADBEEF;
        #1 chk("sb_c3_stall", stall, 1);
        tick();
        mem_valid = 0;
        #1;
        chk("sb_c4_cnt", fifo_count, 1);
        chk("sb_c4_rw", reg_write, 0);
        tick();
        chk("sb_c5_rw", reg_write, 1);
        chk("sb_c5_dst", dst, 7);
        chk("sb_c5_wb", wb, 32'hDEADBEEF);
`ifdef WB_FORWARD_EN
        chk("sb_c5_stall", stall, 0);
        chk("sb_c5_fwd_hit", fwd_a_hit, 1);
        chk("sb_c5_fwd_data", fwd_data, 32'hDEADBEEF);
`else
        chk("sb_c5_stall", stall, 1);
`endif
        tick();
        chk("sb_c6_stall", stall, 0);
        chk("sb_c6_rw", reg_write, 0);
        addr_a = 0;

        // contention: ALU busy cycles 0..5, five loads offered back-to-back from cycle 0
        for (int c = 0; c <= 12; c++) begin
            int li;
            li = (c < 4) ? c : 4;
            alu_valid = c < 6; alu_dst = 9; alu_data = c;
            mem_valid = c < 8; mem_dst = 5'(11 + li); mem_data = 100 + li;
            #1;
            chk($sformatf("ct_c%0d_ready", c), mem_ready, (c >= 4 && c <= 6) ? 0 : 1);
            chk($sformatf("ct_c%0d_cnt", c), fifo_count,
                (c <= 4) ? c : (c <= 6) ? 4 : (c <= 8) ? 3 : (c <= 11) ? 11 - c : 0);
            chk($sformatf("ct_c%0d_rw", c), reg_write, (c >= 1 && c <= 11) ? 1 : 0);
            if (c >= 1 && c <= 6) begin
                chk($sformatf("ct_c%0d_dst", c), dst, 9);
                chk($sformatf("ct_c%0d_wb", c), wb, c - 1);
            end else if (c >= 7 && c <= 11) begin
                chk($sformatf("ct_c%0d_dst", c), dst, 11 + c - 7);
                chk($sformatf("ct_c%0d_wb", c), wb, 100 + c - 7);
            end
            tick();
        end
        mem_valid = 0; alu_valid = 0;

        // x0 results consume their slot but never write or mark pending
        alu_valid = 1; alu_dst = 0; alu_data = 32'h55;
        load_issue = 1; load_dst = 0;
        tick();
        alu_valid = 0; load_issue = 0;
        mem_valid = 1; mem_dst = 0; mem_data = 32'h77;
        #1;
        chk("x0_c1_rw", reg_write, 0);
        chk("x0_c1_stall", stall, 0);
        tick();
        mem_valid = 0;
        #1;
        chk("x0_c2_rw", reg_write, 0);
        chk("x0_c2_cnt", fifo_count, 1);
        chk("x0_c2_stall", stall, 0);
        tick();
        chk("x0_c3_rw", reg_write, 0);
        chk("x0_c3_cnt", fifo_count, 0);
        tick();
        chk("x0_c4_rw", reg_write, 0);

        // reset with three entries queued and a pending load
        alu_valid = 1; alu_dst = 1; alu_data = 32'h11;
        load_issue = 1; load_dst = 20;
        mem_valid = 1; mem_dst = 20; mem_data = 32'hA0;
        tick();
        load_issue = 0; mem_data = 32'hA1;
        tick();
        mem_data = 32'hA2;
        tick();
        mem_valid = 0; addr_a = 20;
        #1;
        chk("mr_cnt_pre", fifo_count, 3);
        chk("mr_stall_pre", stall, 1);
        rst_n = 0;
        #1;
        chk("mr_cnt_rst", fifo_count, 0);
        chk("mr_stall_rst", stall, 0);
        chk("mr_rw_rst", reg_write, 0);
        chk("mr_ready_rst", mem_ready, 1);
        alu_valid = 0;
        tick();
        rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("mr_post%0d_rw", c), reg_write, 0);
            chk($sformatf("mr_post%0d_cnt", c), fifo_count, 0);
            chk($sformatf("mr_post%0d_stall", c), stall, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
